// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider-side constants and FSM state type
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_reconstruct.sv
// rtl/div_reconstruct.sv - sequential u = q*v + r dividend reconstruction, radix-2 shift-add
// Optional operand range check selected by DIV_RECONSTRUCT_CHECK_EN.
module div_reconstruct
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     q,
  input  logic [WIDTH-1:0]     v,
  input  logic [WIDTH-1:0]     r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   u,
  output logic                 range_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   v_q, v_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] addend;

  // Partial product for the current multiplier bit; the accumulator starts at r.
  assign addend = q_q[cnt_q] ? ({{WIDTH{1'b0}}, v_q} << cnt_q) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    v_d       = v_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          q_d     = q;
          v_d     = v;
          acc_d   = {{WIDTH{1'b0}}, r};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_q + addend;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      v_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
    end
  end

  assign u = acc_q;

`ifdef DIV_RECONSTRUCT_CHECK_EN
  logic err_q;

  // Captured from the raw operands on the accepting edge, held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      err_q <= (v == '0) || (r >= v);
    end
  end

  assign range_err = err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
